// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus per-bit tick-sampled debouncer with registered level and edge pulses.
// Define LONG_PRESS_EN to build per-bit hold counters that drive long_press.
module btn_debounce #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned TICK_CYCLES  = 50000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_event,
  output logic [WIDTH-1:0] long_press
);

  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam logic [31:0] TickMax = 32'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] StableMax = SW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [31:0]              tcnt_q, tcnt_d;
  logic                     tick;
  logic [WIDTH-1:0][SW-1:0] scnt_q, scnt_d;
  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     any_q, any_d;

  assign tick   = (tcnt_q == TickMax);
  assign tcnt_d = tick ? 32'd0 : tcnt_q + 32'd1;

  always_comb begin
    scnt_d  = scnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          scnt_d[i] = '0;
        end else if (scnt_q[i] == StableMax) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
          scnt_d[i]  = '0;
        end else begin
          scnt_d[i] = scnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign any_event = any_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HoldMax = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HoldLast = HW'(LONG_TICKS - 1);

  logic [WIDTH-1:0][HW-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0]         lp_q, lp_d;

  // Saturating at LONG_TICKS is what keeps a held button from repeating the pulse.
  always_comb begin
    hcnt_d = hcnt_q;
    lp_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!level_q[i]) begin
        hcnt_d[i] = '0;
      end else if (tick && (hcnt_q[i] != HoldMax)) begin
        hcnt_d[i] = hcnt_q[i] + 1'b1;
        lp_d[i]   = (hcnt_q[i] == HoldLast);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      lp_q   <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      lp_q   <= lp_d;
    end
  end

  assign long_press = lp_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart to the LED output path on the nvboard.
- Synchronizes WIDTH raw button/switch inputs, debounces each bit independently on a shared slow sample tick, and produces a clean level plus single-cycle rise/fall event pulses.
- Sits between the nvboard input pins and user logic, e.g. to step or reverse a LED pattern per button press.

Parameters:
- WIDTH, 16, number of independent input bits.
- TICK_CYCLES, 50000, clk cycles per sample tick (5 ms at 10 MHz); must be >= 1.
- STABLE_TICKS, 4, consecutive disagreeing ticks required to accept a new level; must be >= 1.
- LONG_TICKS, 100, ticks a level must stay high before long_press fires (used only with LONG_PRESS_EN); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- raw_in  in  WIDTH  asynchronous raw inputs from pins, idle low.
- level  out  WIDTH  debounced level, registered.
- rise  out  WIDTH  one-cycle pulse per bit when level goes 0->1.
- fall  out  WIDTH  one-cycle pulse per bit when level goes 1->0.
- any_event  out  1  registered OR of all rise and fall bits, same cycle as those pulses.
- long_press  out  WIDTH  one-cycle long-hold pulse per bit; constant 0 without LONG_PRESS_EN.

Behaviour:
- Clock and reset: clk is the clock. Reset rst is synchronous and active-high; all state updates on posedge clk.
- Reset values: every output, both synchronizer stages, the tick counter and all per-bit counters are 0.
  - level resets to 0 regardless of raw_in.
  - An input held high through reset is re-debounced after reset and produces a rise pulse.
- Synchronizer: 2-FF chain per bit; sync = raw_in delayed 2 cycles.
- Tick generator:
  - tcnt counts 0..TICK_CYCLES-1 and wraps to 0.
  - tick is high for exactly one cycle when tcnt == TICK_CYCLES-1.
  - TICK_CYCLES = 1 means tick is high every cycle.
- Per-bit debounce counter scnt (width clog2(STABLE_TICKS+1)), evaluated only on tick cycles:
  - sync[i] == level[i]: scnt <= 0.
  - sync[i] != level[i] and scnt == STABLE_TICKS-1: level[i] <= sync[i], scnt <= 0.
  - otherwise: scnt <= scnt + 1.
  - Non-tick cycles: scnt and level hold.
- Glitch rejection: any tick on which sync matches level restarts the count. A disturbance shorter than STABLE_TICKS ticks never changes level.
- Event pulses:
  - rise[i] and fall[i] are registered on the same edge that updates level[i]. They are high during the first cycle level shows the new value and low on the next cycle.
  - rise and fall are never both high on the same bit.
  - Several bits may pulse in the same cycle.
- Latency from a raw_in edge to the level change: at least 2 + (STABLE_TICKS-1)*TICK_CYCLES cycles, at most 2 + STABLE_TICKS*TICK_CYCLES + 1 cycles.
- Mid-debounce reset: counters clear and level goes to 0 with no pulses emitted. Debouncing restarts from scratch.
- Width rule: tcnt is 32 bits; TICK_CYCLES must fit in 32 bits.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined: adds a per-bit hold counter hcnt that saturates at LONG_TICKS.
  - While level[i] == 1, hcnt increments on each tick.
  - When hcnt reaches LONG_TICKS, long_press[i] pulses for one cycle and hcnt saturates, so there is no repeat.
  - hcnt clears when level[i] == 0, or on rst.
  - long_press is not included in any_event.
- Not defined: no hold counters are built and long_press is tied to 0.

Test Plan (TICK_CYCLES=4, STABLE_TICKS=3, LONG_TICKS=5, WIDTH=16):
- Reset check: assert rst for 3 cycles with raw_in=16'hFFFF -> level=0, rise=0, fall=0, any_event=0 during reset and on the first cycle after it. After release, all 16 rise bits pulse in the same cycle, 10 to 15 cycles later; level=16'hFFFF.
- Clean press: raw_in[0] 0->1 and held -> rise[0] high for exactly 1 cycle, 10 to 15 cycles after the edge; level[0]=1 in that cycle; any_event=1 in that cycle only; no fall pulse.
- Glitch rejection: raw_in[3] high for 8 cycles (2 ticks) then low -> level[3] stays 0; no rise or fall pulse.
- Release: with level[5]=1, set raw_in[5]=0 -> fall[5] pulses once within 10 to 15 cycles; level[5]=0; rise[5] stays 0.
- Simultaneous activity: raw_in bits 1 and 2 rise on the same cycle while bit 0 falls -> rise[1] and rise[2] pulse together, fall[0] pulses in the same cycle, any_event is a single 1-cycle pulse.
- LONG_PRESS_EN build: hold raw_in[7]=1 -> long_press[7] pulses once, 20 cycles (5 ticks) after rise[7], and does not repeat while held. Release and press again -> long_press[7] pulses again. Non-EN build: long_press stays 0 throughout.
